// File: rtl/ddr_package.sv
// Shared types and default timing constants for the DDR4 refresh scheduler.
// The pull-in window default only exists when REF_PULL_IN_EN is defined.
package ddr_package;

    typedef enum logic [2:0] {
        REF_IDLE,
        REF_TRACK,
        REF_DRAIN,
        REF_ISSUE,
        REF_RFC
    } ref_fsm_type;

    localparam int TREFI_DEFAULT        = 6240;
    localparam int TRFC_DEFAULT         = 280;
    localparam int MAX_POSTPONE_DEFAULT = 8;
    localparam int URGENT_THR_DEFAULT   = 6;
`ifdef REF_PULL_IN_EN
    localparam int PULLIN_WIN_DEFAULT   = 64;
`endif

endpackage

// File: rtl/ddr_ref_interval_timer.sv
// tREFI interval counter: runs 0..TREFI-1 while en is high, clr forces it back to 0.
// tick is high for the single cycle in which the counter wraps.
module ddr_ref_interval_timer
    import ddr_package::*;
#(
    parameter int TREFI = TREFI_DEFAULT
) (
    input  logic clock_t,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam logic [CW-1:0] LAST = CW'(TREFI - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr_refresh_scheduler.sv
// DDR4 refresh scheduler: tracks owed refreshes, forces a drain when debt is high, issues REF, holds tRFC.
// Defining REF_PULL_IN_EN adds idle-window pull-in refreshes banked as credit against future ticks.
//
//  state     | meaning
//  REF_IDLE  | disabled, debt and interval cleared
//  REF_TRACK | counting intervals, refresh opportunistically when RW is idle
//  REF_DRAIN | debt at threshold, ref_urgent asks the RW engine to drain
//  REF_ISSUE | one-cycle REF strobe
//  REF_RFC   | tRFC busy window
module ddr_refresh_scheduler
    import ddr_package::*;
#(
    parameter int TREFI        = TREFI_DEFAULT,
    parameter int TRFC         = TRFC_DEFAULT,
    parameter int MAX_POSTPONE = MAX_POSTPONE_DEFAULT,
    parameter int URGENT_THR   = URGENT_THR_DEFAULT
`ifdef REF_PULL_IN_EN
    ,
    parameter int PULLIN_WIN   = PULLIN_WIN_DEFAULT
`endif
) (
    input  logic       clock_t,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       rw_idle,
    output logic       ref_urgent,
    output logic       ref_cmd,
    output logic       ref_busy,
    output logic [3:0] ref_debt,
    output logic       ref_err
);

    localparam int RW = $clog2(TRFC + 1);
    localparam logic [RW-1:0] RFC_LOAD = RW'(TRFC - 1);
    localparam logic [3:0] DEBT_MAX = 4'(MAX_POSTPONE);
    localparam logic [3:0] DEBT_URG = 4'(URGENT_THR);

    ref_fsm_type   state_q;
    logic [RW-1:0] rfc_q;
    logic [3:0]    debt_q, debt_d;
    logic          err_q, err_d;
    logic          cmd_q, busy_q, urgent_q;
    logic          in_wait, go_idle, tmr_clr, tmr_en, tick;
    logic          issue_dec, tick_debt;
    logic          pull_go, pull_q, credit_avail;

    assign in_wait = (state_q == REF_TRACK) || (state_q == REF_DRAIN);
    assign go_idle = (state_q == REF_IDLE) || (in_wait && !enable) ||
                     ((state_q == REF_RFC) && (rfc_q == '0) && !enable);
    assign tmr_clr = (state_q == REF_IDLE) || (in_wait && !enable);
    assign tmr_en  = !tmr_clr;

    ddr_ref_interval_timer #(
        .TREFI (TREFI)
    ) u_interval (
        .clock_t (clock_t),
        .reset_n (reset_n),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .tick    (tick)
    );

`ifdef REF_PULL_IN_EN
    localparam int IW = $clog2(PULLIN_WIN + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(PULLIN_WIN - 1);

    logic [IW-1:0] idle_cnt_q;
    logic [3:0]    credit_q;
    logic          idle_run;

    assign idle_run     = (state_q == REF_TRACK) && enable && (debt_q == '0) && rw_idle &&
                          (credit_q < DEBT_MAX);
    assign pull_go      = idle_run && (idle_cnt_q == IDLE_LAST);
    assign credit_avail = (credit_q != '0);

    // pull_q marks the ISSUE cycle that was started by the idle window.
    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
            credit_q   <= '0;
            pull_q     <= 1'b0;
        end else begin
            pull_q     <= pull_go;
            idle_cnt_q <= (idle_run && !pull_go) ? idle_cnt_q + 1'b1 : '0;
            if (go_idle) begin
                credit_q <= '0;
            end else if (pull_q && !(tick && credit_avail)) begin
                credit_q <= credit_q + 1'b1;
            end else if (!pull_q && tick && credit_avail) begin
                credit_q <= credit_q - 1'b1;
            end
        end
    end
`else
    assign pull_go      = 1'b0;
    assign pull_q       = 1'b0;
    assign credit_avail = 1'b0;
`endif

    // A tick covered by pull-in credit never reaches the debt counter.
    assign issue_dec = (state_q == REF_ISSUE) && !pull_q;
    assign tick_debt = tick && !credit_avail;

    always_comb begin
        debt_d = debt_q;
        err_d  = err_q | (tick_debt && !issue_dec && (debt_q == DEBT_MAX));
        if (go_idle) begin
            debt_d = '0;
        end else if (tick_debt && !issue_dec && (debt_q != DEBT_MAX)) begin
            debt_d = debt_q + 1'b1;
        end else if (!tick_debt && issue_dec) begin
            debt_d = debt_q - 1'b1;
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            debt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            debt_q <= debt_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= REF_IDLE;
            rfc_q    <= '0;
            cmd_q    <= 1'b0;
            busy_q   <= 1'b0;
            urgent_q <= 1'b0;
        end else begin
            cmd_q    <= 1'b0;
            busy_q   <= 1'b0;
            urgent_q <= 1'b0;
            case (state_q)
                REF_IDLE: begin
                    if (enable) state_q <= REF_TRACK;
                end
                REF_TRACK: begin
                    if (!enable) begin
                        state_q <= REF_IDLE;
                    end else if (debt_q >= DEBT_URG) begin
                        state_q  <= REF_DRAIN;
                        urgent_q <= 1'b1;
                    end else if (((debt_q != '0) && rw_idle) || pull_go) begin
                        state_q <= REF_ISSUE;
                        cmd_q   <= 1'b1;
                    end
                end
                REF_DRAIN: begin
                    if (!enable) begin
                        state_q <= REF_IDLE;
                    end else if (rw_idle) begin
                        state_q <= REF_ISSUE;
                        cmd_q   <= 1'b1;
                    end else begin
                        urgent_q <= 1'b1;
                    end
                end
                REF_ISSUE: begin
                    state_q <= REF_RFC;
                    rfc_q   <= RFC_LOAD;
                    busy_q  <= 1'b1;
                end
                REF_RFC: begin
                    if (rfc_q == '0) begin
                        state_q <= enable ? REF_TRACK : REF_IDLE;
                    end else begin
                        rfc_q  <= rfc_q - 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                default: state_q <= REF_IDLE;
            endcase
        end
    end

    assign ref_urgent = urgent_q;
    assign ref_cmd    = cmd_q;
    assign ref_busy   = busy_q;
    assign ref_debt   = debt_q;
    assign ref_err    = err_q;

endmodule
